pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline-stage register for the five-stage CPU, the generalised successor to the fixed per-stage latches between IF/ID, ID/EX, EX/MEM and MEM/WB. It carries one opaque WIDTH-bit bundle of control, data and exception fields, adds a valid bit and a valid/ready handshake, and supports stall, synchronous flush with bubble insertion, and an optional skid entry. A saturating stall counter feeds the performance monitor.

---
 rtl/pipe_stage_reg.sv | 142 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register: valid/ready handshake, synchronous flush with
// bubble insertion, optional skid entry for a registered in_ready, saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 160,
    parameter int unsigned      SKID   = 1,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int unsigned      CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_is_nop,
    output logic [CNT_W-1:0] stall_cnt
);

    logic             acc;
    logic             pop;
    logic             valid_q;
    logic [WIDTH-1:0] main_q;

    assign acc        = in_valid & in_ready;
    assign pop        = valid_q & out_ready;
    assign out_valid  = valid_q;
    assign out_is_nop = ~valid_q;
    // The bubble mux hides whatever stale payload the unreset data register holds.
    assign out_data   = valid_q ? main_q : BUBBLE;

    if (SKID == 0) begin : g_single

        assign in_ready = ~rst & (~valid_q | out_ready);

        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (flush) begin
                valid_q <= 1'b0;
            end else if (acc) begin
                valid_q <= 1'b1;
            end else if (pop) begin
                valid_q <= 1'b0;
            end
        end

        // NOTE: payload registers are not reset; validity alone decides whether they are observed.
        always_ff @(posedge clk) begin
            if (acc) begin
                main_q <= in_data;
            end
        end

    end else begin : g_skid

        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            FULL  = 2'd2
        } state_t;

        state_t           state_q;
        state_t           state_d;
        logic [WIDTH-1:0] skid_q;
        logic             load_main_in;
        logic             load_main_skid;
        logic             load_skid;

        // in_ready decodes the registered state only, so out_ready never reaches it.
        assign in_ready = ~rst & (state_q != FULL);
        assign valid_q  = (state_q != EMPTY);

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= EMPTY;
            end else begin
                state_q <= state_d;
            end
        end

        always_comb begin
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        load_main_in = 1'b1;
                    end else if (acc) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
            // Flush overrides the handshake; any loads it leaves behind stay invisible.
            if (flush) begin
                state_d = EMPTY;
            end
        end

        always_ff @(posedge clk) begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end

    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (valid_q && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: four instances (both SKID modes, WIDTH 1/16/200)
// compared every cycle against an occupancy-list model, plus hand-computed directed checks.
module tb_pipe_stage_reg;

    localparam int L = 4;
    localparam int SKIDS [L] = '{0, 1, 0, 1};
    localparam int WIDS  [L] = '{16, 16, 1, 200};
    localparam int CNTWS [L] = '{4, 4, 16, 16};
    localparam logic [199:0] BUBS [L] = '{200'h5A5A, 200'h5A5A, 200'h1, {50{4'h9}}};
    localparam logic [199:0] BUB16 = 200'h5A5A;

    logic clk = 1'b0;
    logic rst;
    logic         iv   [L];
    logic         fl   [L];
    logic         ordy [L];
    logic [199:0] id   [L];

    logic         irdy [L];
    logic         ov   [L];
    logic         nop  [L];
    wire  [199:0] od   [L];
    wire  [15:0]  cnt  [L];

    wire [15:0]  od0, od1;
    wire [0:0]   od2;
    wire [199:0] od3;
    wire [3:0]   c0, c1;
    wire [15:0]  c2, c3;

    assign od[0]  = {184'b0, od0};
    assign od[1]  = {184'b0, od1};
    assign od[2]  = {199'b0, od2};
    assign od[3]  = od3;
    assign cnt[0] = {12'b0, c0};
    assign cnt[1] = {12'b0, c1};
    assign cnt[2] = c2;
    assign cnt[3] = c3;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(16), .SKID(0), .BUBBLE(16'h5A5A), .CNT_W(4)) u_l0 (
        .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_data(id[0][15:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od0),
        .out_is_nop(nop[0]), .stall_cnt(c0));

    pipe_stage_reg #(.WIDTH(16), .SKID(1), .BUBBLE(16'h5A5A), .CNT_W(4)) u_l1 (
        .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_data(id[1][15:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od1),
        .out_is_nop(nop[1]), .stall_cnt(c1));

    pipe_stage_reg #(.WIDTH(1), .SKID(0), .BUBBLE(1'b1), .CNT_W(16)) u_l2 (
        .clk(clk), .rst(rst), .flush(fl[2]), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_data(id[2][0:0]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od2),
        .out_is_nop(nop[2]), .stall_cnt(c2));

    pipe_stage_reg #(.WIDTH(200), .SKID(1), .BUBBLE({50{4'h9}}), .CNT_W(16)) u_l3 (
        .clk(clk), .rst(rst), .flush(fl[3]), .in_valid(iv[3]), .in_ready(irdy[3]),
        .in_data(id[3]), .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od3),
        .out_is_nop(nop[3]), .stall_cnt(c3));

    int n_checks;
    int n_fail;
    bit chk_en;

    task automatic check(input string name, input int lane, input logic [199:0] act,
                         input logic [199:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s lane%0d @%0t: got %h, expected %h", name, lane, $time, act, exp);
        end
    endtask

    // Model: each lane is an ordered list of held entries (capacity 1 or 2) plus a counter.
    logic [199:0] mbuf [L][2];
    int           mn   [L];
    int           mcnt [L];

    function automatic logic [199:0] wmask(input int w);
        return {200{1'b1}} >> (200 - w);
    endfunction

    function automatic logic exp_ready(input int l);
        if (rst) return 1'b0;
        if (SKIDS[l] != 0) return (mn[l] < 2);
        return (mn[l] == 0) || ordy[l];
    endfunction

    initial forever begin
        @(posedge clk);
        for (int l = 0; l < L; l++) begin
            if (rst) begin
                mn[l]   = 0;
                mcnt[l] = 0;
            end else begin
                logic acc_m;
                logic pop_m;
                acc_m = iv[l] && exp_ready(l);
                pop_m = (mn[l] > 0) && ordy[l];
                if (mn[l] > 0 && !ordy[l] && mcnt[l] < (1 << CNTWS[l]) - 1)
                    mcnt[l]++;
                if (fl[l]) begin
                    mn[l] = 0;
                end else begin
                    if (pop_m) begin
                        mbuf[l][0] = mbuf[l][1];
                        mn[l]--;
                    end
                    if (acc_m) begin
                        mbuf[l][mn[l]] = id[l] & wmask(WIDS[l]);
                        mn[l]++;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int l = 0; l < L; l++) begin
                check("out_valid", l, 200'(ov[l]), 200'(mn[l] > 0));
                check("out_is_nop", l, 200'(nop[l]), 200'(mn[l] == 0));
                check("out_data", l, od[l], (mn[l] > 0) ? mbuf[l][0] : BUBS[l]);
                check("in_ready", l, 200'(irdy[l]), 200'(exp_ready(l)));
                check("stall_cnt", l, 200'(cnt[l]), 200'(mcnt[l]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic v, input logic [199:0] d, input logic r, input logic f);
        for (int l = 0; l < L; l++) begin
            iv[l]   = v;
            id[l]   = d;
            ordy[l] = r;
            fl[l]   = f;
        end
    endtask

    task automatic check_pair(input string name, input logic [199:0] a0, input logic [199:0] a1,
                              input logic [199:0] exp);
        check(name, 0, a0, exp);
        check(name, 1, a1, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b0;
        for (int l = 0; l < L; l++) begin
            mn[l]   = 0;
            mcnt[l] = 0;
        end
        rst = 1'b1;
        drive_all(1'b1, 200'h1234_ABCD, 1'b1, 1'b0);

        // Reset held for two edges while upstream offers data.
        tick();
        chk_en = 1'b1;
        tick();
        check_pair("rst_out_valid", 200'(ov[0]), 200'(ov[1]), 200'h0);
        check_pair("rst_out_data", od[0], od[1], BUB16);
        check_pair("rst_stall_cnt", 200'(cnt[0]), 200'(cnt[1]), 200'h0);
        check_pair("rst_in_ready", 200'(irdy[0]), 200'(irdy[1]), 200'h0);
        rst = 1'b0;
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_pair("release_in_ready", 200'(irdy[0]), 200'(irdy[1]), 200'h1);

        // Streaming 1..100 with out_ready held high: each value appears one cycle later.
        for (int i = 1; i <= 100; i++) begin
            tick();
            drive_all(1'b1, 200'(i), 1'b1, 1'b0);
            @(negedge clk);
            if (i > 1) check_pair("stream_data", od[0], od[1], 200'(i - 1));
        end
        tick();
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_pair("stream_last", od[0], od[1], 200'd100);
        tick();
        @(negedge clk);
        check_pair("stream_drained", 200'(ov[0]), 200'(ov[1]), 200'h0);

        // Skid: A then B with out_ready low, C offered through five stalled cycles.
        tick();
        drive_all(1'b1, 200'hA, 1'b0, 1'b0);
        tick();
        drive_all(1'b1, 200'hB, 1'b0, 1'b0);
        @(negedge clk);
        check("skid_main_a", 1, od[1], 200'hA);
        check("skid_ready_one", 1, 200'(irdy[1]), 200'h1);
        tick();
        drive_all(1'b1, 200'hC, 1'b0, 1'b0);
        @(negedge clk);
        check("skid_full_ready", 1, 200'(irdy[1]), 200'h0);
        check("skid_full_main", 1, od[1], 200'hA);
        repeat (3) tick();
        tick();
        drive_all(1'b1, 200'hC, 1'b1, 1'b0);
        @(negedge clk);
        check_pair("skid_stall_cnt", 200'(cnt[0]), 200'(cnt[1]), 200'd5);
        check("skid_out_a", 1, od[1], 200'hA);
        check("skid_c_blocked", 1, 200'(irdy[1]), 200'h0);
        tick();
        @(negedge clk);
        check("skid_out_b", 1, od[1], 200'hB);
        check("skid_ready_again", 1, 200'(irdy[1]), 200'h1);
        tick();
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        @(negedge clk);
        check("skid_out_c", 1, od[1], 200'hC);
        tick();
        @(negedge clk);
        check("skid_empty_bubble", 1, od[1], BUB16);

        // Flush while full (lane 1) with D offered and a pop on the same cycle.
        tick();
        drive_all(1'b1, 200'hE, 1'b0, 1'b0);
        tick();
        drive_all(1'b1, 200'hF, 1'b0, 1'b0);
        tick();
        drive_all(1'b1, 200'hD, 1'b1, 1'b1);
        @(negedge clk);
        check_pair("flush_pop_data", od[0], od[1], 200'hE);
        check("flush_full_ready", 1, 200'(irdy[1]), 200'h0);
        tick();
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        @(negedge clk);
        check_pair("flush_valid", 200'(ov[0]), 200'(ov[1]), 200'h0);
        check_pair("flush_bubble", od[0], od[1], BUB16);
        check_pair("flush_cnt_kept", 200'(cnt[0]), 200'(cnt[1]), 200'd6);
        tick();
        @(negedge clk);
        check_pair("flush_no_d", 200'(ov[0]), 200'(ov[1]), 200'h0);

        // Saturation of the 4-bit counters: 19 more stalled cycles on top of 6.
        tick();
        drive_all(1'b1, 200'h77, 1'b0, 1'b0);
        repeat (20) tick();
        @(negedge clk);
        check_pair("sat_cnt", 200'(cnt[0]), 200'(cnt[1]), 200'd15);
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        repeat (4) tick();

        // Random valid/ready/flush traffic with one mid-stream reset.
        for (int c = 0; c < 10000; c++) begin
            tick();
            rst = (c == 5000);
            for (int l = 0; l < L; l++) begin
                iv[l]   = 1'($urandom_range(0, 1));
                id[l]   = 200'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
                ordy[l] = ($urandom_range(0, 3) != 0);
                fl[l]   = ($urandom_range(0, 39) == 0);
            end
        end
        tick();
        rst = 1'b0;
        drive_all(1'b0, 200'h0, 1'b1, 1'b0);
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
